// File: rtl/dec_stage_1_if.sv
// Valid/ready bus of the stage-1 Hamming decoder: codeword ingress, decoded-word egress,
// status flags and saturating error counters.
interface dec_stage_1_if #(
    parameter int unsigned CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       codeword_in;
    logic [1:0]        work_mod;
    logic              out_valid;
    logic              out_ready;
    logic [25:0]       data_out;
    logic [5:0]        syndrome_out;
    logic              err_corr;
    logic              err_par;
    logic              err_uncorr;
    logic              err_mode;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  uncorr_cnt;

    modport master (
        output in_valid, codeword_in, work_mod, out_ready,
        input  in_ready, out_valid, data_out, syndrome_out,
        input  err_corr, err_par, err_uncorr, err_mode, corr_cnt, uncorr_cnt
    );

    modport slave (
        input  in_valid, codeword_in, work_mod, out_ready,
        output in_ready, out_valid, data_out, syndrome_out,
        output err_corr, err_par, err_uncorr, err_mode, corr_cnt, uncorr_cnt
    );
endinterface

// File: rtl/dec_stage_1.sv
// Stage-1 Hamming decoder: recompute parity, form syndrome, classify and correct a single info
// bit error, and deliver the info word through a two-stage valid/ready pipeline.
module dec_stage_1 #(
    parameter logic [155:0] H1_MAT = 156'hE0_0000_3400_000B,
    parameter logic [155:0] H2_MAT = 156'h1FC_0000_78E0_0019_B400_055B,
    parameter logic [155:0] H3_MAT = 156'h3_FFF8_00FF_01FC_3C3C_78EC_CCD9_B6AA_AD5B,
    parameter int unsigned  CNT_W  = 16
) (
    input logic           clk,
    input logic           rst,
    dec_stage_1_if.slave  bus
);
    localparam int unsigned IW = 26;
    localparam int unsigned PW = 6;
    localparam int unsigned HW = PW * IW;

    function automatic logic [IW-1:0] h_row(input logic [1:0] mode, input int unsigned r);
        logic [HW-1:0] mat;
        case (mode)
            2'b00:   mat = H1_MAT;
            2'b01:   mat = H2_MAT;
            2'b10:   mat = H3_MAT;
            default: mat = '0;
        endcase
        return mat[IW*r +: IW];
    endfunction

    function automatic int unsigned k_of(input logic [1:0] mode);
        case (mode)
            2'b00:   return 4;
            2'b01:   return 11;
            2'b10:   return 26;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned p_of(input logic [1:0] mode);
        case (mode)
            2'b00:   return 4;
            2'b01:   return 5;
            2'b10:   return 6;
            default: return 0;
        endcase
    endfunction

    // Handshake
    logic ready_en_q;
    logic s1_valid_q, s2_valid_q;
    logic adv1, adv2, in_ready, accept, deliver;

    assign adv2     = ~s2_valid_q | bus.out_ready;
    assign adv1     = ~s1_valid_q | adv2;
    assign in_ready = adv1 & ready_en_q;
    assign accept   = bus.in_valid & in_ready;
    assign deliver  = s2_valid_q & bus.out_ready;

    // Stage 1 field split and parity recompute
    logic [IW-1:0] info_in;
    logic [PW-1:0] par_in, rpar_in;

    always_comb begin
        info_in = '0;
        par_in  = '0;
        case (bus.work_mod)
            2'b00: begin
                info_in = IW'(bus.codeword_in[7:4]);
                par_in  = PW'(bus.codeword_in[3:0]);
            end
            2'b01: begin
                info_in = IW'(bus.codeword_in[15:5]);
                par_in  = PW'(bus.codeword_in[4:0]);
            end
            2'b10: begin
                info_in = bus.codeword_in[31:6];
                par_in  = bus.codeword_in[5:0];
            end
            default: ;
        endcase
        rpar_in = '0;
        for (int unsigned r = 0; r < PW; r++) begin
            if (r < p_of(bus.work_mod)) begin
                rpar_in[r] = ^(info_in & h_row(bus.work_mod, r));
            end
        end
    end

    logic [IW-1:0] s1_info_q;
    logic [PW-1:0] s1_par_q, s1_rpar_q;
    logic [1:0]    s1_mode_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_info_q  <= '0;
            s1_par_q   <= '0;
            s1_rpar_q  <= '0;
            s1_mode_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (adv1) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_info_q <= info_in;
                    s1_par_q  <= par_in;
                    s1_rpar_q <= rpar_in;
                    s1_mode_q <= bus.work_mod;
                end
            end
        end
    end

    // Stage 2 syndrome decode; the downward scan leaves the lowest matching column
    logic [PW-1:0] syn, col;
    logic [IW-1:0] row;
    logic          hit, syn_one;
    logic [4:0]    hit_idx;

    always_comb begin
        syn     = s1_rpar_q ^ s1_par_q;
        hit     = 1'b0;
        hit_idx = '0;
        col     = '0;
        row     = '0;
        for (int j = int'(IW) - 1; j >= 0; j--) begin
            col = '0;
            for (int unsigned r = 0; r < PW; r++) begin
                row = h_row(s1_mode_q, r);
                if (r < p_of(s1_mode_q)) begin
                    col[r] = row[j];
                end
            end
            if (j < int'(k_of(s1_mode_q)) && col == syn) begin
                hit     = 1'b1;
                hit_idx = 5'(j);
            end
        end
        syn_one = (syn != '0) && ((syn & (syn - PW'(1))) == '0);
    end

    logic [IW-1:0] data_d, data_q;
    logic [PW-1:0] syn_d, syn_q;
    logic          corr_d, corr_q, par_d, par_q, unc_d, unc_q, mode_d, mode_q;

    always_comb begin
        data_d = s1_info_q;
        syn_d  = syn;
        corr_d = 1'b0;
        par_d  = 1'b0;
        unc_d  = 1'b0;
        mode_d = 1'b0;
        if (s1_mode_q == 2'b11) begin
            mode_d = 1'b1;
            data_d = '0;
            syn_d  = '0;
        end else if (syn == '0) begin
            data_d = s1_info_q;
        end else if (hit) begin
            corr_d = 1'b1;
            data_d = s1_info_q ^ (IW'(1) << hit_idx);
        end else if (syn_one) begin
            par_d = 1'b1;
        end else begin
            unc_d = 1'b1;
        end
    end

    logic [CNT_W-1:0] corr_cnt_q, uncorr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q   <= 1'b0;
            data_q       <= '0;
            syn_q        <= '0;
            corr_q       <= 1'b0;
            par_q        <= 1'b0;
            unc_q        <= 1'b0;
            mode_q       <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    data_q <= data_d;
                    syn_q  <= syn_d;
                    corr_q <= corr_d;
                    par_q  <= par_d;
                    unc_q  <= unc_d;
                    mode_q <= mode_d;
                end
            end
            if (deliver && (corr_q || par_q) && corr_cnt_q != '1) begin
                corr_cnt_q <= corr_cnt_q + CNT_W'(1);
            end
            if (deliver && (unc_q || mode_q) && uncorr_cnt_q != '1) begin
                uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = s2_valid_q;
    assign bus.data_out     = data_q;
    assign bus.syndrome_out = syn_q;
    assign bus.err_corr     = corr_q;
    assign bus.err_par      = par_q;
    assign bus.err_uncorr   = unc_q;
    assign bus.err_mode     = mode_q;
    assign bus.corr_cnt     = corr_cnt_q;
    assign bus.uncorr_cnt   = uncorr_cnt_q;
endmodule

// File: tb/tb_dec_stage_1.sv
// Bench for dec_stage_1: directed and random codewords checked against a syndrome-table model
// through an in-order scoreboard, with stall, reset and counter saturation scenarios.
module tb_dec_stage_1;
    localparam logic [155:0] H1 = 156'hE0_0000_3400_000B;
    localparam logic [155:0] H2 = 156'h1FC_0000_78E0_0019_B400_055B;
    localparam logic [155:0] H3 = 156'h3_FFF8_00FF_01FC_3C3C_78EC_CCD9_B6AA_AD5B;

    typedef struct packed {
        logic [25:0] data;
        logic [5:0]  syn;
        logic [3:0]  flags;   // {mode, uncorr, par, corr}
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dec_stage_1_if bus ();
    dec_stage_1 dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    exp_t        q[$];
    logic [15:0] corr_m = 0, unc_m = 0;
    int          rdy_mode = 0;
    int          pidx = 0;
    bit          stall_prev = 0;
    logic [69:0] snap_prev = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [25:0] hrow(input logic [1:0] m, input int r);
        logic [155:0] mat;
        mat = (m == 2'd0) ? H1 : (m == 2'd1) ? H2 : (m == 2'd2) ? H3 : '0;
        return 26'(mat >> (26 * r));
    endfunction

    function automatic int k_of(input logic [1:0] m);
        return (m == 2'd0) ? 4 : (m == 2'd1) ? 11 : 26;
    endfunction

    function automatic int p_of(input logic [1:0] m);
        return (m == 2'd0) ? 4 : (m == 2'd1) ? 5 : 6;
    endfunction

    function automatic exp_t model(input logic [31:0] cw, input logic [1:0] m);
        exp_t        e;
        int          k, p;
        logic [25:0] info, row;
        logic [5:0]  recv, syn, col;
        bit          found;
        e = '0;
        if (m == 2'b11) begin
            e.flags = 4'b1000;
            return e;
        end
        k    = k_of(m);
        p    = p_of(m);
        info = 26'((64'(cw) >> p) & ((64'd1 << k) - 1));
        recv = 6'(64'(cw) & ((64'd1 << p) - 1));
        syn  = '0;
        for (int r = 0; r < p; r++) begin
            row    = hrow(m, r);
            syn[r] = (^(info & row)) ^ recv[r];
        end
        e.syn  = syn;
        e.data = info;
        if (syn == '0) return e;
        found = 0;
        for (int j = 0; j < k; j++) begin
            if (!found) begin
                col = '0;
                for (int r = 0; r < p; r++) begin
                    row    = hrow(m, r);
                    col[r] = row[j];
                end
                if (col == syn) begin
                    found   = 1;
                    e.data  = info ^ (26'd1 << j);
                    e.flags = 4'b0001;
                end
            end
        end
        if (!found) e.flags = ($countones(syn) == 1) ? 4'b0010 : 4'b0100;
        return e;
    endfunction

    function automatic logic [31:0] encode(input logic [25:0] info, input logic [1:0] m);
        logic [5:0]  par;
        logic [25:0] row;
        par = '0;
        for (int r = 0; r < p_of(m); r++) begin
            row    = hrow(m, r);
            par[r] = ^(info & row);
        end
        return 32'((64'(info) << p_of(m)) | 64'(par));
    endfunction

    // Consumer readiness pattern, changed just after each rising edge
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: begin
                bus.out_ready = (pidx == 0 || pidx == 3);
                pidx = (pidx + 1) % 4;
            end
            2: bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Scoreboard and hold checker, sampled mid-cycle
    always @(negedge clk) begin
        logic [69:0] snap;
        exp_t        e;
        snap = {bus.out_valid, bus.data_out, bus.syndrome_out, bus.err_mode, bus.err_uncorr,
                bus.err_par, bus.err_corr, bus.corr_cnt, bus.uncorr_cnt, 4'b0};
        if (!rst) begin
            chk("reset outputs", 64'({bus.out_valid, bus.in_ready, bus.data_out, bus.syndrome_out,
                bus.err_mode, bus.err_uncorr, bus.err_par, bus.err_corr}), 64'd0);
            chk("reset counters", 64'({bus.corr_cnt, bus.uncorr_cnt}), 64'd0);
            q.delete();
            corr_m     = 0;
            unc_m      = 0;
            stall_prev = 0;
        end else begin
            chk("corr_cnt", 64'(bus.corr_cnt), 64'(corr_m));
            chk("uncorr_cnt", 64'(bus.uncorr_cnt), 64'(unc_m));
            if (stall_prev) chk("hold during stall", 64'(snap >> 6), 64'(snap_prev >> 6));
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected output word", 64'(bus.data_out), 64'hDEAD);
                end else begin
                    e = q.pop_front();
                    chk("data_out", 64'(bus.data_out), 64'(e.data));
                    chk("syndrome_out", 64'(bus.syndrome_out), 64'(e.syn));
                    chk("flags", 64'({bus.err_mode, bus.err_uncorr, bus.err_par, bus.err_corr}),
                        64'(e.flags));
                    if ((e.flags[0] || e.flags[1]) && corr_m != 16'hFFFF) corr_m++;
                    if ((e.flags[2] || e.flags[3]) && unc_m != 16'hFFFF) unc_m++;
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.codeword_in, bus.work_mod));
            stall_prev = bus.out_valid && !bus.out_ready;
            snap_prev  = snap;
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the word
    task automatic send(input logic [31:0] cw, input logic [1:0] m);
        bit acc;
        int t;
        acc = 0;
        t   = 0;
        bus.in_valid    = 1'b1;
        bus.codeword_in = cw;
        bus.work_mod    = m;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL send timeout: got no accept expected accept of %0h", cw);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        bus.in_valid = 1'b0;
        do begin
            @(negedge clk);
            t++;
        end while ((q.size() != 0 || bus.out_valid) && t < 500);
        chk("drain pending words", 64'(q.size()), 64'd0);
    endtask

    initial begin
        exp_t        e;
        logic [1:0]  m;
        logic [25:0] info;
        logic [31:0] cw;
        int          pos;

        bus.in_valid    = 1'b0;
        bus.codeword_in = '0;
        bus.work_mod    = '0;
        bus.out_ready   = 1'b0;
        rst             = 1'b0;

        // Model pinned to hand-computed values
        e = model(32'h0000_00A2, 2'b00);
        chk("model A2", 64'(e), 64'({26'hA, 6'h0, 4'b0000}));
        e = model(32'h0000_0082, 2'b00);
        chk("model 82", 64'(e), 64'({26'hA, 6'h5, 4'b0001}));
        e = model(32'h0000_00A3, 2'b00);
        chk("model A3", 64'(e), 64'({26'hA, 6'h1, 4'b0010}));
        e = model(32'h0000_00AB, 2'b00);
        chk("model AB", 64'(e), 64'({26'hA, 6'h9, 4'b0100}));
        e = model(32'hFFFF_FFFF, 2'b11);
        chk("model mode11", 64'(e), 64'({26'h0, 6'h0, 4'b1000}));

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("in_ready after reset", 64'(bus.in_ready), 64'd1);
        chk("no stale out_valid", 64'(bus.out_valid), 64'd0);

        // Latency of one clean word with the consumer always ready
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b1;
        bus.codeword_in = 32'h0000_00A2;
        bus.work_mod    = 2'b00;
        @(negedge clk);
        chk("accept ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("latency 1 cycle", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("latency 2 cycles", 64'(bus.out_valid), 64'd1);
        chk("latency data", 64'(bus.data_out), 64'hA);
        @(posedge clk);
        #1;

        // Single-error classes and illegal mode
        send(32'h0000_0082, 2'b00);
        send(32'h0000_00A3, 2'b00);
        send(32'h0000_00AB, 2'b00);
        send(32'h1234_5678, 2'b11);
        drain();
        chk("corr_cnt literal", 64'(bus.corr_cnt), 64'd2);
        chk("uncorr_cnt literal", 64'(bus.uncorr_cnt), 64'd2);
        @(posedge clk);
        #1;

        // Back-to-back with consumer pattern 1,0,0,1
        rdy_mode = 1;
        send(32'h0000_00A2, 2'b00);
        send(32'h0000_0082, 2'b00);
        send(32'h0000_00A3, 2'b00);
        send(32'h0000_00AB, 2'b00);
        send(32'h0000_0000, 2'b11);
        send(encode(26'h5A5, 2'b01) ^ 32'h0000_0100, 2'b01);
        send(encode(26'h2B3C4D5, 2'b10) ^ 32'h0000_0001, 2'b10);
        send(32'hFFFF_FF82, 2'b00);
        drain();
        @(posedge clk);
        #1;

        // Random single-bit flips in modes 01 and 10 under random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 200; i++) begin
            m    = 2'($urandom_range(1, 2));
            info = 26'($urandom) & 26'((64'd1 << k_of(m)) - 1);
            cw   = encode(info, m);
            pos  = $urandom_range(0, k_of(m) + p_of(m) - 1);
            cw   = cw ^ (32'd1 << pos);
            if (m == 2'b01) cw[31:16] = 16'($urandom);
            e = model(cw, m);
            chk("rand model data", 64'(e.data), 64'(info));
            chk("rand model flag", 64'(e.flags), (pos < p_of(m)) ? 64'd2 : 64'd1);
            send(cw, m);
        end
        drain();
        @(posedge clk);
        #1;

        // Reset with a full, stalled pipeline discards everything
        rdy_mode = 3;
        @(posedge clk);
        #1;
        send(32'h0000_0082, 2'b00);
        send(32'h0000_00AB, 2'b00);
        bus.codeword_in = 32'h0000_00A3;
        @(negedge clk);
        chk("stalled pipeline full", 64'({bus.out_valid, bus.in_ready}), 64'b10);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid reset out_valid", 64'(bus.out_valid), 64'd0);
        bus.in_valid = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("no replay after reset", 64'(bus.out_valid), 64'd0);
        chk("ready after mid reset", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Counter saturation with a continuous stream of correctable words
        bus.in_valid    = 1'b1;
        bus.codeword_in = 32'h0000_0082;
        bus.work_mod    = 2'b00;
        repeat (65539) @(posedge clk);
        #1;
        drain();
        chk("corr_cnt saturated", 64'(bus.corr_cnt), 64'hFFFF);
        chk("uncorr_cnt untouched", 64'(bus.uncorr_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
